// File: rtl/fp_pkg.sv
// fp_pkg: binary32 constants and the sign/exponent/fraction view shared by the FP adder
package fp_pkg;

    localparam int          EXP_W   = 8;
    localparam int          FRAC_W  = 23;
    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_t;

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: 27-bit leading-zero counter, returns 27 for an all-zero input
module fp_lzc (
    input  logic [26:0] v_i,
    output logic [4:0]  cnt_o
);

    // scan upward so the most significant set bit decides the count
    always_comb begin
        cnt_o = 5'd27;
        for (int i = 0; i < 27; i++) if (v_i[i]) cnt_o = 5'(26 - i);
    end

endmodule

// File: rtl/fp_add.sv
// fp_add: binary32 adder, round-to-nearest-even, one registered output stage
module fp_add
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] result
);

    fp_t               ua, ub, big, sml;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big, sub, carry, rnd;
    logic [EXP_W-1:0]  eb, es, diff, lim;
    logic [23:0]       sig_b, sig_s;
    logic [49:0]       ext;
    logic [26:0]       mb, ms, mn;
    logic [27:0]       sum;
    logic [4:0]        lz, sh;
    logic [8:0]        en, ep;
    logic [31:0]       packed_r, result_d, result_q;
    logic              out_valid_q;

    assign ua     = fp_t'(a);
    assign ub     = fp_t'(b);
    assign a_nan  = (ua.exp == '1) && (ua.frac != '0);
    assign b_nan  = (ub.exp == '1) && (ub.frac != '0);
    assign a_inf  = (ua.exp == '1) && (ua.frac == '0);
    assign b_inf  = (ub.exp == '1) && (ub.frac == '0);
    assign a_zero = (ua.exp == '0) && (ua.frac == '0);
    assign b_zero = (ub.exp == '0) && (ub.frac == '0);

    // order by magnitude; subnormals sit at effective exponent 1 with no hidden bit
    assign a_big = {ua.exp, ua.frac} >= {ub.exp, ub.frac};
    assign big   = a_big ? ua : ub;
    assign sml   = a_big ? ub : ua;
    assign eb    = (big.exp == '0) ? 8'd1 : big.exp;
    assign es    = (sml.exp == '0) ? 8'd1 : sml.exp;
    assign diff  = eb - es;
    assign sig_b = {big.exp != '0, big.frac};
    assign sig_s = {sml.exp != '0, sml.frac};

    // 27-bit working format: 24-bit significand, guard, round, sticky
    assign ext = {sig_s, 26'd0} >> diff;
    assign ms  = (diff >= 8'd26) ? {26'd0, |sig_s} : {ext[49:24], |ext[23:0]};
    assign mb  = {sig_b, 3'd0};
    assign sub = big.sign ^ sml.sign;
    assign sum = sub ? {1'b0, mb} - {1'b0, ms} : {1'b0, mb} + {1'b0, ms};

    fp_lzc u_lzc (
        .v_i   (sum[26:0]),
        .cnt_o (lz)
    );

    // normalise: carry shifts right, otherwise shift left but never below exponent 1
    assign carry = sum[27];
    assign lim   = eb - 8'd1;
    assign sh    = ({3'd0, lz} <= lim) ? lz : lim[4:0];
    assign mn    = carry ? {sum[27:2], sum[1] | sum[0]} : sum[26:0] << sh;
    assign en    = carry ? {1'b0, eb} + 9'd1 : {1'b0, eb} - {4'd0, sh};
    assign ep    = mn[26] ? en : 9'd0;

    // rounding increment on the packed word lets carries ripple into the exponent
    assign rnd      = mn[2] & (mn[1] | mn[0] | mn[3]);
    assign packed_r = {ep, mn[25:3]} + {31'd0, rnd};

    // special operands take priority over the arithmetic path
    always_comb begin
        result_d = (a_nan | b_nan | (a_inf & b_inf & (ua.sign ^ ub.sign))) ? QNAN
                 : a_inf ? a
                 : b_inf ? b
                 : (a_zero & b_zero) ? {ua.sign & ub.sign, 31'd0}
                 : a_zero ? b
                 : b_zero ? a
                 : (sum == '0) ? 32'd0
                 : (packed_r[31:23] >= 9'd255) ? (POS_INF | {big.sign, 31'd0})
                 : {big.sign, packed_r[30:0]};
    end

    // output register: result only updates on a valid input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) result_q <= result_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_fp_add.sv
// tb_fp_add: scoreboard bench for fp_add against an exact-integer binary32 reference
module tb_fp_add;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a_s = '0;
    logic [31:0] b_s = '0;
    logic        out_valid;
    logic [31:0] result;

    item_t       q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_res = '0;

    fp_add dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a_s),
        .b         (b_s),
        .out_valid (out_valid),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // exact value in units of 2^-149
    function automatic logic [299:0] mag(input logic [31:0] x);
        logic [299:0] s = {276'd0, x[30:23] != 8'd0, x[22:0]};
        return (x[30:23] == 8'd0) ? s : s << (x[30:23] - 1);
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
        logic [299:0] mx = mag(x);
        logic [299:0] my = mag(y);
        logic [299:0] m, q_v, rem, half;
        logic s;
        int p, k;
        bit xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        bit yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        bit xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        bit yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        if (xn || yn || (xi && yi && x[31] != y[31])) return 32'h7FC00000;
        if (xi) return x;
        if (yi) return y;
        if (mx == 0 && my == 0) return {x[31] & y[31], 31'd0};
        if (mx == 0) return y;
        if (my == 0) return x;
        if (x[31] == y[31]) begin m = mx + my; s = x[31]; end
        else if (mx > my) begin m = mx - my; s = x[31]; end
        else if (my > mx) begin m = my - mx; s = y[31]; end
        else return 32'd0;
        p = 0;
        for (int i = 299; i > 0; i--) if (m[i]) begin p = i; break; end
        if (p <= 23) return {s, m[30:0]};
        k    = p - 23;
        q_v  = m >> k;
        rem  = m - (q_v << k);
        half = 300'd1 << (k - 1);
        if (rem > half || (rem == half && q_v[0])) q_v = q_v + 1;
        if (q_v[24]) begin q_v = q_v >> 1; k++; end
        if (k + 1 >= 255) return {s, 8'hFF, 23'd0};
        return {s, 8'(k + 1), q_v[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op(input logic [31:0] ref_v);
        logic [31:0] sp [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                                32'h7FC00001, 32'h00000001, 32'h7F7FFFFF, 32'h00800000};
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 7))
            0: r = sp[$urandom_range(0, 7)];
            1: r[30:23] = 8'd0;
            2: r = {~ref_v[31], ref_v[30:0] ^ (31'($urandom) & 31'h7)};
            3: r[30:23] = ref_v[30:23] + 8'($urandom_range(0, 3)) - 8'd1;
            4: r[30:23] = 8'hFE;
            default: ;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a_s = x;
        b_s = y;
        q.push_back('{a: x, b: y, exp: e});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // monitor: pops on every valid output, otherwise the result must hold
    initial forever begin
        item_t it;
        @(negedge clk);
        if (!rst_n) last_res = '0;
        else if (out_valid) begin
            if (q.size() == 0) check("unexpected_valid", result, 32'hxxxxxxxx);
            else begin
                it = q.pop_front();
                if (result !== it.exp)
                    $display("FAIL add a=%08h b=%08h: got %08h expected %08h", it.a, it.b, result, it.exp);
                n_cmp++;
                if (result !== it.exp) n_err++;
                last_res = it.exp;
            end
        end else check("hold", result, last_res);
    end

    initial begin
        logic [31:0] dir [10][3] = '{
            '{32'h3F115B57, 32'h3FAB851F, 32'h3FF432CA},
            '{32'h00000000, 32'h3FAB851F, 32'h3FAB851F},
            '{32'h00000000, 32'h00000000, 32'h00000000},
            '{32'h3F800000, 32'h3F800000, 32'h40000000},
            '{32'h3F800000, 32'hBF800000, 32'h00000000},
            '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},
            '{32'h7F800000, 32'hFF800000, 32'h7FC00000},
            '{32'h00000001, 32'h00000001, 32'h00000002},
            '{32'hC0000000, 32'h3F800000, 32'hBF800000},
            '{32'h80000000, 32'h80000000, 32'h80000000}};
        logic [31:0] x, y;
        #2;
        check("reset_result", result, 32'd0);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) issue(dir[i][0], dir[i][1], dir[i][2]);
        idle();
        idle();
        issue(32'h40490FDB, 32'h3F800000, ref_add(32'h40490FDB, 32'h3F800000));
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midstream_reset_result", result, 32'd0);
        check("midstream_reset_valid", {31'd0, out_valid}, 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            x = rnd_op($urandom);
            y = rnd_op(x);
            issue(x, y, ref_add(x, y));
            if ($urandom_range(0, 9) == 0) idle();
        end
        repeat (3) idle();
        check("drain", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_add.md
# fp_add

Single-precision IEEE-754 floating-point adder with one registered output stage. Takes two binary32 operands, aligns, adds or subtracts the significands, normalizes, and rounds to nearest-even. It is the add datapath used by the FP execution unit and is purely arithmetic: no exception flags and no rounding-mode input.

## Interface
- No parameters; the format is fixed binary32.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a/b are valid this cycle
- a  input  32  operand A, binary32
- b  input  32  operand B, binary32
- out_valid  output  1  result valid, registered
- result  output  32  a+b, binary32, registered

## Operation
- Unpack each operand into sign, 8-bit exponent and 23-bit fraction.
  - Hidden bit is 1 when exp≠0.
  - Subnormals (exp=0) use hidden bit 0 and effective exponent 1.
- Special cases, checked in priority order:
  - Any NaN in, or +inf + -inf: result = 0x7FC00000 (canonical quiet NaN).
  - One or both operands inf (same sign): result = that inf.
  - Both operands zero: sign = sA & sB, so -0 + -0 = -0 and all other combinations give +0.
  - One operand zero: result = the other operand, bit-exact.
- Alignment:
  - Order operands by magnitude ({exp,frac} compare).
  - Right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits.
  - A shift of 26 or more collapses the whole significand into sticky.
- Effective operation is add when signs are equal, otherwise subtract (larger minus smaller). Result sign is the sign of the larger-magnitude operand.
- Normalization:
  - Carry-out: shift right by 1, exponent +1, and fold the shifted-out bit into sticky.
  - Leading zeros after subtract: left shift by the LZC, limited so the exponent does not go below 1. The result becomes subnormal when the limit is hit.
- Rounding is round-to-nearest, ties-to-even on guard/round/sticky. A mantissa carry from rounding increments the exponent.
- Exact cancellation (equal magnitudes, opposite signs) gives +0 (0x00000000).
- Overflow (exponent ≥ 255 after rounding) gives ±inf (0x7F800000 | sign).

## Timing
- The datapath is combinational from a/b into a single register stage. Latency is 1 cycle, with throughput of 1 per cycle.
- On rst_n low, asynchronously: result = 0x00000000 and out_valid = 0.
- Each rising edge: out_valid ← in_valid, and result ← f(a,b) when in_valid=1. When in_valid=0, result holds its previous value.
- There is no backpressure and no ready signal.
- Reset asserted mid-stream discards the in-flight result. The first valid output after release appears one cycle after the first in_valid.

## Structure
- Shared package fp_pkg holds:
  - Constants: EXP_W=8, FRAC_W=23, BIAS=127, QNAN=32'h7FC00000, POS_INF=32'h7F800000.
  - A packed struct for the sign/exp/frac unpack.
- One sub-module, fp_lzc: a 27-bit leading-zero counter used by the normalizer.
- Everything else (unpack, align, add, normalize, round, pack, output register) lives in fp_add.

## Test plan
Every case is applied with in_valid=1 and checked one cycle later with out_valid=1.
- a=0x3F115B57, b=0x3FAB851F -> 0x3FF432CA (tie rounds to even).
- a=0x00000000, b=0x3FAB851F -> 0x3FAB851F; a=b=0x00000000 -> 0x00000000.
- a=b=0x3F800000 -> 0x40000000 (carry-out renormalization); a=0x3F800000, b=0xBF800000 -> 0x00000000.
- a=b=0x7F7FFFFF -> 0x7F800000 (overflow); a=0x7F800000, b=0xFF800000 -> 0x7FC00000.
- Subnormal case: a=0x00000001, b=0x00000001 -> 0x00000002. Negative case: a=0xC0000000, b=0x3F800000 -> 0xBF800000.
- Reset and valid:
  - Assert rst_n=0 mid-stream: result=0 and out_valid=0 immediately, with no clock edge needed.
  - With in_valid=0, result holds its previous value and out_valid=0.
